// File: rtl/rr_mux_select_stage.sv
// rr_mux_select_stage: round-robin lane arbiter driving an N:1 mux select, with a
// valid/ready output register capturing the mux result and optional per-grant burst lock.
module rr_mux_select_stage #(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3,
    parameter int BURST = 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [SEL_W-1:0] S,
    input  logic [WIDTH-1:0] mux_O,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_lane,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {ARB, LOCK} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, owner_q, owner_d, sel_q, sel_d, out_lane_q, out_lane_d;
    logic [SEL_W-1:0] g, start, cand;
    logic [7:0]       beat_cnt_q, beat_cnt_d, next_cnt;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, load_en, grant, found, new_owner;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
        return (x == SEL_W'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            owner_q     <= '0;
            sel_q       <= '0;
            beat_cnt_q  <= '0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            sel_q       <= sel_d;
            beat_cnt_q  <= beat_cnt_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_valid_q <= out_valid_d;
        end
    end

    // A locked owner that is still requesting wins outright; otherwise scan past it.
    always_comb begin
        load_en = !out_valid_q || out_ready;
        start   = (state_q == LOCK) ? wrap_inc(owner_q) : ptr_q;
        found   = 1'b0;
        g       = start;
        cand    = start;
        for (int k = 0; k < N; k++) begin
            cand = SEL_W'((int'(start) + k) % N);
            if (!found && in_valid[cand]) begin
                found = 1'b1;
                g     = cand;
            end
        end
        if (state_q == LOCK && in_valid[owner_q]) g = owner_q;
        grant    = ASYNCRESETN && load_en && (|in_valid);
        in_ready = grant ? N'(1) << g : '0;
        S        = grant ? g : sel_q;
    end

    always_comb begin
        new_owner   = (state_q != LOCK) || (g != owner_q);
        next_cnt    = new_owner ? 8'd1 : beat_cnt_q + 8'd1;
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        sel_d       = sel_q;
        beat_cnt_d  = beat_cnt_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_valid_d = out_valid_q;
        if (grant) begin
            out_data_d  = mux_O;
            out_lane_d  = g;
            out_valid_d = 1'b1;
            sel_d       = g;
            if (next_cnt >= 8'(BURST)) begin
                state_d    = ARB;
                ptr_d      = wrap_inc(g);
                beat_cnt_d = '0;
            end else begin
                state_d    = LOCK;
                owner_d    = g;
                beat_cnt_d = next_cnt;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
            if (state_q == LOCK) begin
                state_d    = ARB;
                ptr_d      = wrap_inc(owner_q);
                beat_cnt_d = '0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_select_stage.sv
// tb_rr_mux_select_stage: two instances (BURST=1 and BURST=3) on shared stimulus,
// checked against a lane-scanning reference model of the arbitration rules.
module tb_rr_mux_select_stage;
    localparam int N = 5;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  iv = '0;
    logic        ordy = 1'b0;
    logic [4:0]  ir [2];
    logic [2:0]  s [2];
    logic [2:0]  ol [2];
    logic [31:0] od [2];
    logic [31:0] mo [2];
    logic        ov [2];

    int n_cmp = 0;
    int n_err = 0;

    int          m_ptr [2], m_owner [2], m_run [2], m_sel [2], m_ol [2], eg [2];
    bit          m_lock [2], m_ov [2];
    logic [31:0] m_od [2];
    logic [4:0]  e_ready [2], a_ready [2];
    logic [2:0]  e_s [2], a_s [2];

    always #5 CLK = ~CLK;

    assign mo[0] = 32'hA0 + {29'd0, s[0]};
    assign mo[1] = 32'hA0 + {29'd0, s[1]};

    rr_mux_select_stage #(.N(5), .WIDTH(32), .SEL_W(3), .BURST(1)) dut1 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .in_valid(iv), .in_ready(ir[0]), .S(s[0]),
        .mux_O(mo[0]), .out_data(od[0]), .out_lane(ol[0]), .out_valid(ov[0]), .out_ready(ordy));

    rr_mux_select_stage #(.N(5), .WIDTH(32), .SEL_W(3), .BURST(3)) dut3 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .in_valid(iv), .in_ready(ir[1]), .S(s[1]),
        .mux_O(mo[1]), .out_data(od[1]), .out_lane(ol[1]), .out_valid(ov[1]), .out_ready(ordy));

    function automatic int pick(int k);
        int st;
        if (!rst_n || (m_ov[k] && !ordy) || iv == 5'd0) return -1;
        if (m_lock[k] && iv[m_owner[k]]) return m_owner[k];
        st = m_lock[k] ? (m_owner[k] + 1) % N : m_ptr[k];
        for (int i = 0; i < N; i++) if (iv[(st + i) % N]) return (st + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_owner[k] = 0; m_run[k] = 0; m_sel[k] = 0; m_ol[k] = 0;
            m_lock[k] = 0; m_ov[k] = 0; m_od[k] = '0;
        end
    endtask

    // Drive one cycle of stimulus, sample the combinational handshake, then advance the model.
    task automatic step(input logic [4:0] v, input logic r);
        int b;
        iv = v; ordy = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            eg[k]      = pick(k);
            e_ready[k] = (eg[k] < 0) ? 5'd0 : 5'(1 << eg[k]);
            e_s[k]     = (eg[k] < 0) ? 3'(m_sel[k]) : 3'(eg[k]);
            a_ready[k] = ir[k];
            a_s[k]     = s[k];
        end
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 1 : 3;
            if (eg[k] >= 0) begin
                m_od[k] = 32'hA0 + 32'(eg[k]); m_ol[k] = eg[k]; m_ov[k] = 1; m_sel[k] = eg[k];
                m_run[k] = (!m_lock[k] || eg[k] != m_owner[k]) ? 1 : m_run[k] + 1;
                if (m_run[k] >= b) begin
                    m_lock[k] = 0; m_ptr[k] = (eg[k] + 1) % N; m_run[k] = 0;
                end else begin
                    m_lock[k] = 1; m_owner[k] = eg[k];
                end
            end else if (!m_ov[k] || ordy) begin
                m_ov[k] = 0;
                if (m_lock[k]) begin
                    m_lock[k] = 0; m_ptr[k] = (m_owner[k] + 1) % N; m_run[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(posedge CLK);
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        iv = 5'h1F; ordy = 1'b1;
        #2 rst_n = 1'b0;
        #6;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ir[k] !== 5'd0) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b want 00000", k, ir[k]); end
            n_cmp++; if (ov[k] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]); end
            n_cmp++; if (s[k] !== 3'd0) begin n_err++; $display("FAIL reset_S[%0d] got %0d want 0", k, s[k]); end
        end
        @(posedge CLK);
        #1 rst_n = 1'b1;
        model_reset();
        step(5'h1F, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (a_ready[k] !== 5'b00001) begin n_err++; $display("FAIL first_grant[%0d] got %b want 00001", k, a_ready[k]); end
            n_cmp++; if (ol[k] !== 3'd0 || ov[k] !== 1'b1) begin n_err++; $display("FAIL first_out[%0d] got lane %0d valid %b want lane 0 valid 1", k, ol[k], ov[k]); end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(5'h1F, 1'b1);
            n_cmp++; if (a_ready[0] !== 5'(1 << (i % 5))) begin n_err++; $display("FAIL rr_ready[%0d] got %b want lane %0d", i, a_ready[0], i % 5); end
            n_cmp++; if (ol[0] !== 3'(i % 5)) begin n_err++; $display("FAIL rr_lane[%0d] got %0d want %0d", i, ol[0], i % 5); end
            n_cmp++; if (od[0] !== 32'hA0 + 32'(i % 5)) begin n_err++; $display("FAIL rr_data[%0d] got %h want %h", i, od[0], 32'hA0 + 32'(i % 5)); end
        end
    endtask

    task automatic test_stall();
        logic [2:0]  last_lane;
        logic [31:0] last_data;
        last_lane = ol[0]; last_data = od[0];
        for (int i = 0; i < 3; i++) begin
            step(5'h1F, 1'b0);
            n_cmp++; if (a_ready[0] !== 5'd0) begin n_err++; $display("FAIL stall_ready[%0d] got %b want 00000", i, a_ready[0]); end
            n_cmp++; if (od[0] !== last_data || ov[0] !== 1'b1) begin n_err++; $display("FAIL stall_data[%0d] got %h/%b want %h/1", i, od[0], ov[0], last_data); end
            n_cmp++; if (a_s[0] !== last_lane) begin n_err++; $display("FAIL stall_S[%0d] got %0d want %0d", i, a_s[0], last_lane); end
        end
        step(5'h1F, 1'b1);
        n_cmp++; if (ol[0] !== 3'((int'(last_lane) + 1) % 5)) begin n_err++; $display("FAIL stall_resume got %0d want %0d", ol[0], (int'(last_lane) + 1) % 5); end
    endtask

    task automatic test_burst();
        int          exp_l [11] = '{1, 1, 1, 3, 3, 3, 1, 1, 1, 3, 1};
        logic [4:0]  v;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            v = (i == 10) ? 5'b00010 : 5'b01010;
            step(v, 1'b1);
            n_cmp++; if (a_ready[1] !== 5'(1 << exp_l[i])) begin n_err++; $display("FAIL burst_ready[%0d] got %b want lane %0d", i, a_ready[1], exp_l[i]); end
            n_cmp++; if (ol[1] !== 3'(exp_l[i])) begin n_err++; $display("FAIL burst_lane[%0d] got %0d want %0d", i, ol[1], exp_l[i]); end
        end
    endtask

    task automatic test_wrap();
        int exp_l [4] = '{4, 0, 4, 0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step((i == 0) ? 5'h10 : 5'h11, 1'b1);
            n_cmp++; if (ol[0] !== 3'(exp_l[i]) || a_s[0] !== 3'(exp_l[i])) begin n_err++; $display("FAIL wrap[%0d] got lane %0d S %0d want %0d", i, ol[0], a_s[0], exp_l[i]); end
        end
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        step(5'h04, 1'b1);
        step(5'h04, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (ov[k] !== 1'b0 || ir[k] !== 5'd0) begin n_err++; $display("FAIL midreset[%0d] got valid %b ready %b want 0 00000", k, ov[k], ir[k]); end
        end
        #1 rst_n = 1'b1;
        model_reset();
        step(5'h1F, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (a_ready[k] !== 5'b00001 || ol[k] !== 3'd0) begin n_err++; $display("FAIL midreset_grant[%0d] got %b lane %0d want lane 0", k, a_ready[k], ol[k]); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom), ($urandom % 4) != 0);
            for (int k = 0; k < 2; k++) begin
                n_cmp++; if (a_ready[k] !== e_ready[k]) begin n_err++; $display("FAIL rnd_ready[%0d/%0d] got %b want %b", i, k, a_ready[k], e_ready[k]); end
                n_cmp++; if (a_s[k] !== e_s[k]) begin n_err++; $display("FAIL rnd_S[%0d/%0d] got %0d want %0d", i, k, a_s[k], e_s[k]); end
                n_cmp++; if (ov[k] !== m_ov[k]) begin n_err++; $display("FAIL rnd_valid[%0d/%0d] got %b want %b", i, k, ov[k], m_ov[k]); end
                if (m_ov[k]) begin
                    n_cmp++; if (ol[k] !== 3'(m_ol[k]) || od[k] !== m_od[k]) begin n_err++; $display("FAIL rnd_out[%0d/%0d] got %0d/%h want %0d/%h", i, k, ol[k], od[k], m_ol[k], m_od[k]); end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_stall();
        test_burst();
        test_wrap();
        test_reset_mid_lock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
